// File: rtl/cmd_parse_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cmd_parse_pkg
// Brief    : Shared encodings for the host-command parser and the execution
//            stage: FSM states, frame markers, function codes, defaults.
// Revision : 1.0 - initial release
// ============================================================================
package cmd_parse_pkg;

  // Parser states, one per expected byte position plus the issue wait
  typedef enum logic [2:0] {
    SIDLE  = 3'd0,
    SADDR  = 3'd1,
    SFUNC  = 3'd2,
    SPARH  = 3'd3,
    SPARL  = 3'd4,
    STAIL  = 3'd5,
    SISSUE = 3'd6
  } state_t;

  // Frame markers
  localparam logic [7:0] HEAD = 8'hF0;
  localparam logic [7:0] TAIL = 8'hFF;

  // Host function codes; the set commands echo back as their check codes
  localparam logic [2:0] FN_RATE_CHK = 3'd1;
  localparam logic [2:0] FN_NUM_CHK  = 3'd2;
  localparam logic [2:0] FN_DATA     = 3'd3;
  localparam logic [2:0] FN_ADDR_CHK = 3'd4;
  localparam logic [2:0] FN_SET_RATE = 3'd5;
  localparam logic [2:0] FN_SET_NUM  = 3'd6;

  // Configuration register reset defaults
  localparam logic [15:0] RATE_DEFAULT_C = 16'd1000;
  localparam logic [15:0] NUM_DEFAULT_C  = 16'd2000;

  // A function byte is legal only when it is one of the six codes
  function automatic logic func_legal(input logic [7:0] b);
    return (b >= 8'd1) && (b <= 8'd6);
  endfunction

  // Command code handed to the execution stage for a given function
  function automatic logic [2:0] issue_code(input logic [2:0] func);
    case (func)
      FN_SET_RATE: issue_code = FN_RATE_CHK;
      FN_SET_NUM:  issue_code = FN_NUM_CHK;
      default:     issue_code = func;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/cmd_parse_timeout.sv
`default_nettype none
// ============================================================================
// Module   : cmd_byte_timeout
// Brief    : Saturating inter-byte counter; expire flags a stalled frame.
// Revision : 1.0 - initial release
// ============================================================================
module cmd_byte_timeout #(
  parameter int BYTE_TIMEOUT = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam int             CW    = $clog2(BYTE_TIMEOUT + 1);
  localparam logic [CW-1:0]  LIMIT = CW'(BYTE_TIMEOUT);

  logic [CW-1:0] count;

  // Count idle cycles inside a frame; hold at the limit instead of wrapping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign expire = (count == LIMIT);

endmodule
`default_nettype wire

// File: rtl/cmd_parse.sv
`default_nettype none
// ============================================================================
// Module   : cmd_parse
// Brief    : Host-command front end. Frames F0/addr/func/ph/pl/FF requests,
//            holds the sampling configuration and issues command strobes.
// Revision : 1.0 - initial release
// ============================================================================
module cmd_parse
  import cmd_parse_pkg::*;
#(
  parameter int          BYTE_TIMEOUT = 100000,
  parameter logic [15:0] RATE_DEFAULT = RATE_DEFAULT_C,
  parameter logic [15:0] NUM_DEFAULT  = NUM_DEFAULT_C
) (
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic        I_rx_data_valid,
  input  logic [7:0]  I_rx_data,
  input  logic [7:0]  I_device_addr,
  input  logic        I_excutate_valid,
  output logic        O_cmd_valid,
  output logic [2:0]  O_cmd_data,
  output logic [15:0] O_sampling_rate,
  output logic [15:0] O_sampling_num,
  output logic        O_frame_err
);

  state_t      state, state_n;
  logic        addr_match, addr_match_n;
  logic [2:0]  func, func_n;
  logic [7:0]  param_hi, param_hi_n;
  logic [7:0]  param_lo, param_lo_n;
  logic [2:0]  code, code_n;
  logic        cmd_valid, cmd_valid_n;
  logic [2:0]  cmd_data, cmd_data_n;
  logic        frame_err, frame_err_n;
  logic [15:0] rate, rate_n;
  logic [15:0] num, num_n;

  logic        in_frame;
  logic        expire;
  logic [15:0] param;

  assign in_frame = (state == SADDR) || (state == SFUNC) || (state == SPARH) ||
                    (state == SPARL) || (state == STAIL);
  assign param    = {param_hi, param_lo};

  // Counter restarts on every byte and stays parked outside a frame
  cmd_byte_timeout #(
    .BYTE_TIMEOUT (BYTE_TIMEOUT)
  ) u_timeout (
    .clk    (I_clk),
    .rst_n  (I_rst_n),
    .clear  (I_rx_data_valid || !in_frame),
    .run    (in_frame),
    .expire (expire)
  );

  // State, frame fields and registered outputs
  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      state      <= SIDLE;
      addr_match <= 1'b0;
      func       <= '0;
      param_hi   <= '0;
      param_lo   <= '0;
      code       <= '0;
      cmd_valid  <= 1'b0;
      cmd_data   <= '0;
      frame_err  <= 1'b0;
      rate       <= RATE_DEFAULT;
      num        <= NUM_DEFAULT;
    end else begin
      state      <= state_n;
      addr_match <= addr_match_n;
      func       <= func_n;
      param_hi   <= param_hi_n;
      param_lo   <= param_lo_n;
      code       <= code_n;
      cmd_valid  <= cmd_valid_n;
      cmd_data   <= cmd_data_n;
      frame_err  <= frame_err_n;
      rate       <= rate_n;
      num        <= num_n;
    end
  end

  // Next-state, field capture, config update and strobe generation
  always_comb begin
    state_n      = state;
    addr_match_n = addr_match;
    func_n       = func;
    param_hi_n   = param_hi;
    param_lo_n   = param_lo;
    code_n       = code;
    cmd_valid_n  = 1'b0;
    cmd_data_n   = cmd_data;
    frame_err_n  = 1'b0;
    rate_n       = rate;
    num_n        = num;

    if (in_frame && expire) begin
      // A stalled frame is abandoned; a byte landing now is discarded too
      state_n     = SIDLE;
      frame_err_n = 1'b1;
    end else begin
      case (state)
        SIDLE: begin
          if (I_rx_data_valid && (I_rx_data == HEAD)) begin
            state_n = SADDR;
          end
        end
        SADDR: begin
          if (I_rx_data_valid) begin
            addr_match_n = (I_rx_data == I_device_addr);
            state_n      = SFUNC;
          end
        end
        SFUNC: begin
          if (I_rx_data_valid) begin
            if (func_legal(I_rx_data)) begin
              func_n  = I_rx_data[2:0];
              state_n = SPARH;
            end else begin
              frame_err_n = 1'b1;
              state_n     = SIDLE;
            end
          end
        end
        SPARH: begin
          if (I_rx_data_valid) begin
            param_hi_n = I_rx_data;
            state_n    = SPARL;
          end
        end
        SPARL: begin
          if (I_rx_data_valid) begin
            param_lo_n = I_rx_data;
            state_n    = STAIL;
          end
        end
        STAIL: begin
          if (I_rx_data_valid) begin
            if (I_rx_data != TAIL) begin
              frame_err_n = 1'b1;
              state_n     = SIDLE;
            end else if (!addr_match) begin
              // Frame for another unit: consume quietly
              state_n = SIDLE;
            end else begin
              if (func == FN_SET_RATE) rate_n = param;
              if (func == FN_SET_NUM)  num_n  = param;
              code_n  = issue_code(func);
              state_n = SISSUE;
            end
          end
        end
        SISSUE: begin
          // Host is not supposed to talk while a reply is pending
          if (I_rx_data_valid) begin
            frame_err_n = 1'b1;
          end
          if (I_excutate_valid) begin
            cmd_valid_n = 1'b1;
            cmd_data_n  = code;
            state_n     = SIDLE;
          end
        end
        default: begin
          state_n = SIDLE;
        end
      endcase
    end
  end

  assign O_cmd_valid     = cmd_valid;
  assign O_cmd_data      = cmd_data;
  assign O_frame_err     = frame_err;
  assign O_sampling_rate = rate;
  assign O_sampling_num  = num;

endmodule
`default_nettype wire

// File: tb/tb_cmd_parse.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmd_parse
// Brief    : Scoreboard bench for cmd_parse: directed frames plus random
//            frames judged by a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cmd_parse;

  localparam int          TO       = 40;
  localparam logic [7:0]  DEV      = 8'h05;
  localparam logic [15:0] RATE_DEF = 16'd1000;
  localparam logic [15:0] NUM_DEF  = 16'd2000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic [7:0]  dev_addr = DEV;
  logic        exec_ok = 1'b1;
  logic        cmd_valid;
  logic [2:0]  cmd_data;
  logic [15:0] s_rate;
  logic [15:0] s_num;
  logic        frame_err;

  cmd_parse #(
    .BYTE_TIMEOUT (TO),
    .RATE_DEFAULT (RATE_DEF),
    .NUM_DEFAULT  (NUM_DEF)
  ) dut (
    .I_clk            (clk),
    .I_rst_n          (rst_n),
    .I_rx_data_valid  (rx_valid),
    .I_rx_data        (rx_data),
    .I_device_addr    (dev_addr),
    .I_excutate_valid (exec_ok),
    .O_cmd_valid      (cmd_valid),
    .O_cmd_data       (cmd_data),
    .O_sampling_rate  (s_rate),
    .O_sampling_num   (s_num),
    .O_frame_err      (frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  typedef struct {
    int          at;
    logic [2:0]  code;
    logic [15:0] rate;
    logic [15:0] num;
  } cmd_exp_t;

  cmd_exp_t cmd_q[$];
  int       err_q[$];

  // Reference configuration as the host has set it so far
  logic [15:0] m_rate = RATE_DEF;
  logic [15:0] m_num  = NUM_DEF;

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
  endtask

  // Reply code the execution stage should receive for a host function
  function automatic logic [2:0] exp_code(input logic [7:0] f);
    if (f == 8'd5) return 3'd1;
    if (f == 8'd6) return 3'd2;
    return f[2:0];
  endfunction

  function automatic int pick(input int gap);
    return (gap < 0) ? int'($urandom_range(0, 3)) : gap;
  endfunction

  // One-cycle byte strobe followed by idle cycles; entered and left at posedge+1
  task automatic send_byte(input logic [7:0] b, input int idle);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat (idle) begin @(posedge clk); #1; end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Send one frame and predict its outcome from the frame-level rules.
  // lat: strobe cycle offset from tail strobe, or <0 when it will never come.
  task automatic do_frame(input logic [7:0] a, input logic [7:0] f,
                          input logic [7:0] ph, input logic [7:0] pl,
                          input logic [7:0] tl, input int gap, input int lat,
                          output int t_tail);
    logic [15:0] p;
    cmd_exp_t    e;
    p = {ph, pl};
    send_byte(8'hF0, pick(gap));
    send_byte(a, pick(gap));
    if (f < 8'd1 || f > 8'd6) begin
      err_q.push_back(cyc + 1);
      t_tail = cyc;
      send_byte(f, 0);
      return;
    end
    send_byte(f, pick(gap));
    send_byte(ph, pick(gap));
    send_byte(pl, pick(gap));
    t_tail = cyc;
    if (tl != 8'hFF) begin
      err_q.push_back(cyc + 1);
    end else if (a == dev_addr) begin
      if (f == 8'd5) m_rate = p;
      if (f == 8'd6) m_num  = p;
      if (lat >= 0) begin
        e.at = cyc + lat; e.code = exp_code(f); e.rate = m_rate; e.num = m_num;
        cmd_q.push_back(e);
      end
    end
    send_byte(tl, 0);
    // One cycle after the tail the configuration must already reflect it
    chk("rate_after_tail", s_rate, m_rate);
    chk("num_after_tail", s_num, m_num);
    idle_cycles(1);
  endtask

  // Monitor: every strobe the DUT presents must match the oldest prediction
  always @(negedge clk) begin
    if (cmd_valid) begin
      if (cmd_q.size() == 0) begin
        chk("cmd_unexpected", cmd_valid, 0);
      end else begin
        cmd_exp_t e;
        e = cmd_q.pop_front();
        chk("cmd_cycle", cyc, e.at);
        chk("cmd_code", cmd_data, e.code);
        chk("cmd_rate", s_rate, e.rate);
        chk("cmd_num", s_num, e.num);
      end
    end
    if (frame_err) begin
      if (err_q.size() == 0) begin
        chk("err_unexpected", frame_err, 0);
      end else begin
        chk("err_cycle", cyc, err_q.pop_front());
      end
    end
  end

  initial begin : stim
    int t;
    int ta;
    logic [7:0] a, f, tl, j;

    // Reset state
    rst_n = 1'b0;
    idle_cycles(3);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_cmd_data", cmd_data, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_rate", s_rate, RATE_DEF);
    chk("rst_num", s_num, NUM_DEF);
    rst_n = 1'b1;
    idle_cycles(2);

    // Data reply request, then set-rate with echo, then foreign address
    do_frame(DEV, 8'd3, 8'h00, 8'h00, 8'hFF, 0, 2, t);
    idle_cycles(3);
    do_frame(DEV, 8'd5, 8'h03, 8'hE8, 8'hFF, 0, 2, t);
    idle_cycles(3);
    do_frame(8'h07, 8'd1, 8'h00, 8'h00, 8'hFF, 0, 2, t);
    do_frame(DEV, 8'd2, 8'h00, 8'h00, 8'hFF, 0, 2, t);
    do_frame(DEV, 8'd6, 8'h12, 8'h34, 8'hFF, 1, 2, t);
    idle_cycles(3);

    // Bad tail and illegal function code
    do_frame(DEV, 8'd1, 8'h00, 8'h00, 8'hFE, 0, 2, t);
    do_frame(DEV, 8'd7, 8'h00, 8'h00, 8'hFF, 0, 2, t);
    idle_cycles(3);

    // Silence inside a frame aborts it; a following frame still works
    send_byte(8'hF0, 0);
    ta = cyc;
    err_q.push_back(ta + TO + 2);
    send_byte(DEV, TO + 5);
    do_frame(DEV, 8'd4, 8'h00, 8'h00, 8'hFF, 0, 2, t);
    idle_cycles(3);

    // A byte on the expiry cycle loses to the timeout
    send_byte(8'hF0, 0);
    ta = cyc;
    err_q.push_back(ta + TO + 2);
    send_byte(DEV, TO);
    send_byte(8'h01, 5);

    // A byte one cycle before expiry is still accepted, at every position
    do_frame(DEV, 8'd1, 8'hAB, 8'hCD, 8'hFF, TO - 1, 2, t);
    idle_cycles(3);

    // Busy executor: stray byte flagged, one strobe after executor frees up
    exec_ok = 1'b0;
    do_frame(DEV, 8'd3, 8'h00, 8'h01, 8'hFF, 0, 501, t);
    idle_cycles(10);
    err_q.push_back(cyc + 1);
    send_byte(8'h55, 0);
    while (cyc < t + 500) idle_cycles(1);
    exec_ok = 1'b1;
    idle_cycles(5);

    // Reset while waiting to issue drops the command and restores config
    exec_ok = 1'b0;
    do_frame(DEV, 8'd5, 8'h00, 8'h10, 8'hFF, 0, -1, t);
    idle_cycles(4);
    rst_n = 1'b0;
    idle_cycles(2);
    rst_n = 1'b1;
    m_rate = RATE_DEF;
    m_num  = NUM_DEF;
    exec_ok = 1'b1;
    idle_cycles(10);
    chk("rate_after_reset", s_rate, RATE_DEF);
    chk("num_after_reset", s_num, NUM_DEF);

    // Random frames, junk between them, back-to-back bytes allowed
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        j = 8'($urandom);
        if (j == 8'hF0) j = 8'h0F;
        send_byte(j, $urandom_range(0, 2));
      end
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : DEV;
      if ($urandom_range(0, 7) == 0) f = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(7, 255));
      else f = 8'($urandom_range(1, 6));
      tl = 8'hFF;
      if ($urandom_range(0, 5) == 0) begin
        tl = 8'($urandom);
        if (tl == 8'hFF) tl = 8'hFE;
      end
      do_frame(a, f, 8'($urandom), 8'($urandom), tl, -1, 2, t);
    end
    idle_cycles(10);

    chk("cmd_queue_drained", cmd_q.size(), 0);
    chk("err_queue_drained", err_q.size(), 0);
    chk("final_rate", s_rate, m_rate);
    chk("final_num", s_num, m_num);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Hard stop in case stimulus ever stalls
  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/cmd_parse.md
# cmd_parse

Host-command front end of the UART sampling link. It consumes bytes from the UART receiver and frames/validates host requests of the form 0xF0, addr, func, param_hi, param_lo, 0xFF. It holds the sampling-rate and sampling-number configuration registers. It issues a 3-bit command pulse to the command-execution stage, which builds the reply frame, only when that stage reports idle.

## Interface
Parameters:
- BYTE_TIMEOUT, 100000: max clock cycles between bytes inside a frame before the frame is aborted.
- RATE_DEFAULT, 16'd1000: reset value of O_sampling_rate.
- NUM_DEFAULT, 16'd2000: reset value of O_sampling_num.

Ports:
- I_clk  in  1  single clock; all logic rising-edge.
- I_rst_n  in  1  synchronous, active-low reset.
- I_rx_data_valid  in  1  one-cycle strobe, I_rx_data holds a received byte.
- I_rx_data  in  8  received byte.
- I_device_addr  in  8  this unit's address.
- I_excutate_valid  in  1  execution stage idle/ready for a command.
- O_cmd_valid  out  1  one-cycle command strobe to execution stage.
- O_cmd_data  out  3  command code, valid with O_cmd_valid.
- O_sampling_rate  out  16  sampling-rate config register.
- O_sampling_num  out  16  sampling-number config register.
- O_frame_err  out  1  one-cycle pulse on any rejected frame or dropped byte.

## Operation
- States: SIDLE, SADDR, SFUNC, SPARH, SPARL, STAIL, SISSUE. Each byte advances one state.
- SIDLE: byte 0xF0 → SADDR. Any other byte is ignored, with no error.
- SADDR: latch addr_match = (byte == I_device_addr) → SFUNC.
- SFUNC: latch func[2:0] when byte is in 1..6 → SPARH. Any other value → O_frame_err, SIDLE.
- SPARH/SPARL: latch param[15:8] / param[7:0].
- STAIL: byte must be 0xFF, else O_frame_err and SIDLE.
  - Good tail with addr_match=0 → SIDLE silently, no config change.
  - Good tail with match → SISSUE.
- Function codes and their actions:
  - 1 rate check: issues 1.
  - 2 num check: issues 2.
  - 3 data reply: issues 3.
  - 4 addr check: issues 4.
  - 5 set rate: O_sampling_rate ← param, then issues 1 (echo).
  - 6 set num: O_sampling_num ← param, then issues 2 (echo).
- Config register write happens on the cycle the good tail is accepted, before the issue.
- SISSUE: wait for I_excutate_valid=1. Then O_cmd_valid=1 for exactly one cycle with O_cmd_data=issued code → SIDLE.
- Bytes arriving while in SISSUE are dropped and pulse O_frame_err. The pending command is kept.
- Timeout counter:
  - Cleared on every accepted byte and in SIDLE/SISSUE.
  - Increments in SADDR..STAIL.
  - Reaching BYTE_TIMEOUT → SIDLE with an O_frame_err pulse.
  - Counter width is clog2(BYTE_TIMEOUT+1) and it saturates; it never wraps.
- A byte arriving on the same cycle as the timeout: the timeout wins and the byte is discarded.

## Timing
- Reset (I_rst_n=0 at a clock edge):
  - state SIDLE.
  - O_cmd_valid=0, O_cmd_data=0, O_frame_err=0.
  - O_sampling_rate=RATE_DEFAULT, O_sampling_num=NUM_DEFAULT.
  - Timeout counter 0.
- Reset mid-frame discards the partial frame. Reset in SISSUE drops the pending command.
- All outputs are registered.
- Tail strobe at cycle T with executor idle: state is SISSUE at T+1. O_cmd_valid is high during T+2, since I_excutate_valid is sampled in SISSUE.
- Executor busy: O_cmd_valid is asserted the cycle after I_excutate_valid is first sampled high in SISSUE. The module never strobes while I_excutate_valid=0.
- Config outputs change at T+1 after a good set-tail, which is at least 1 cycle before the echo O_cmd_valid.
- O_frame_err is registered, 1 cycle after the offending byte or timeout.
- I_rx_data_valid is assumed ≤1 strobe per cycle. Back-to-back strobes on consecutive cycles must be accepted.

## Structure
- Shared package: state encodings; frame constants HEAD=8'hF0, TAIL=8'hFF; function codes 1..6; reset defaults. The execution stage uses the same codes and markers.
- One natural sub-module, cmd_byte_timeout: the saturating inter-byte counter with clear and expire outputs.
- The FSM and config registers stay in cmd_parse.

## Test plan
- Addr 8'h05, frame F0 05 03 00 00 FF, executor idle → single O_cmd_valid, O_cmd_data=3, two cycles after the tail strobe. O_frame_err stays 0.
- F0 05 05 03 E8 FF → O_sampling_rate=16'h03E8 one cycle after the tail, then O_cmd_valid with code 1. O_sampling_num unchanged.
- F0 07 01 00 00 FF with addr 05 → no O_cmd_valid, no O_frame_err, config unchanged. Next F0 05 02 00 00 FF → code 2.
- Bad tail F0 05 01 00 00 FE → O_frame_err pulse, no command. Func 7 → error after the func byte.
- Timeout: F0 05, then silence for BYTE_TIMEOUT cycles → O_frame_err, SIDLE. A following full valid frame is accepted.
- Execution stage busy (I_excutate_valid=0) for 500 cycles after the tail, one extra byte sent meanwhile → O_frame_err for that byte. Exactly one O_cmd_valid, on the cycle after I_excutate_valid rises. Reset asserted in SISSUE → no strobe.
